// File: rtl/ifft_pkg.sv
// Shared constants, complex sample type and index helpers for the IFFT output reorder stage.
package ifft_pkg;

    localparam int DW   = 29;
    localparam int LOGN = 5;
    localparam int N    = 1 << LOGN;

    typedef logic [LOGN-1:0] idx_t;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef enum logic {
        S_IDLE,
        S_READ
    } rd_state_t;

    function automatic idx_t bitrev(input idx_t a);
        idx_t r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ifft_bitrev_reorder_if.sv
// Sample stream bundle: bit-reversed input side and natural-order output side.
interface ifft_bitrev_reorder_if;
    import ifft_pkg::*;

    logic                 in_valid;
    logic signed [DW-1:0] dir;
    logic signed [DW-1:0] dii;
    logic                 out_valid;
    logic                 out_last;
    idx_t                 out_idx;
    logic signed [DW-1:0] dor;
    logic signed [DW-1:0] doi;

    modport master (
        output in_valid, dir, dii,
        input  out_valid, out_last, out_idx, dor, doi
    );

    modport slave (
        input  in_valid, dir, dii,
        output out_valid, out_last, out_idx, dor, doi
    );

endinterface

// File: rtl/ifft_bitrev_ram.sv
// Ping-pong pair of N-entry complex banks: one synchronous write port, one asynchronous read port.
module ifft_bitrev_ram
    import ifft_pkg::*;
(
    input  logic  clk,
    input  logic  i_we,
    input  logic  i_wbank,
    input  idx_t  i_waddr,
    input  cplx_t i_wdata,
    input  logic  i_rbank,
    input  idx_t  i_raddr,
    output cplx_t o_rdata
);

    cplx_t r_mem [2][N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wbank][i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_rbank][i_raddr];

endmodule

// File: rtl/ifft_bitrev_reorder.sv
// Reorders bit-reversed IFFT frames into natural order through ping-pong banks.
// Optional 1/N output normalisation with round-half-up when IFFT_SCALE_EN is defined.
module ifft_bitrev_reorder
    import ifft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    ifft_bitrev_reorder_if.slave  bus
);

    localparam idx_t LAST_IDX = idx_t'(N - 1);

    function automatic logic signed [DW-1:0] out_scale(input logic signed [DW-1:0] x);
`ifdef IFFT_SCALE_EN
        localparam logic signed [DW:0] SAT_MAX = (DW+1)'((64'sd1 <<< (DW - 1)) - 64'sd1);
        logic signed [DW:0] w_sum;
        logic signed [DW:0] w_shr;
        w_sum = {x[DW-1], x} + (DW+1)'(16);
        w_shr = w_sum >>> LOGN;
        if (w_shr > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end
        return w_shr[DW-1:0];
`else
        return x;
`endif
    endfunction

    idx_t                 r_wcnt;
    logic                 r_wbank;
    logic                 r_frame_ready;
    logic                 r_ready_bank;

    rd_state_t            r_state;
    idx_t                 r_rcnt;
    logic                 r_rbank;

    logic                 r_out_valid;
    logic                 r_out_last;
    idx_t                 r_out_idx;
    logic signed [DW-1:0] r_dor;
    logic signed [DW-1:0] r_doi;

    cplx_t                w_wdata;
    cplx_t                w_rd_data;
    logic                 w_present;
    logic                 w_rd_bank;
    idx_t                 w_rd_addr;

    assign w_wdata = '{re: bus.dir, im: bus.dii};

    ifft_bitrev_ram u_ram (
        .clk     (clk),
        .i_we    (bus.in_valid),
        .i_wbank (r_wbank),
        .i_waddr (bitrev(r_wcnt)),
        .i_wdata (w_wdata),
        .i_rbank (w_rd_bank),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // r_frame_ready is a one-cycle pulse following the edge that stored sample 31.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt        <= '0;
            r_wbank       <= 1'b0;
            r_frame_ready <= 1'b0;
            r_ready_bank  <= 1'b0;
        end else begin
            r_frame_ready <= 1'b0;
            if (bus.in_valid) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (r_wcnt == LAST_IDX) begin
                    r_wbank       <= ~r_wbank;
                    r_frame_ready <= 1'b1;
                    r_ready_bank  <= r_wbank;
                end
            end
        end
    end

    // Starting from IDLE presents index 0 straight away so a frame appears one edge after it completes.
    always_comb begin
        w_present = 1'b0;
        w_rd_bank = r_rbank;
        w_rd_addr = r_rcnt;
        if (r_state == S_READ) begin
            w_present = 1'b1;
        end else if (r_frame_ready) begin
            w_present = 1'b1;
            w_rd_bank = r_ready_bank;
            w_rd_addr = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rcnt      <= '0;
            r_rbank     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_idx   <= '0;
            r_dor       <= '0;
            r_doi       <= '0;
        end else begin
            r_out_valid <= w_present;
            r_out_last  <= w_present && (w_rd_addr == LAST_IDX);
            if (w_present) begin
                r_out_idx <= w_rd_addr;
                r_dor     <= out_scale(w_rd_data.re);
                r_doi     <= out_scale(w_rd_data.im);
            end
            case (r_state)
                S_IDLE: begin
                    if (r_frame_ready) begin
                        r_state <= S_READ;
                        r_rbank <= r_ready_bank;
                        r_rcnt  <= idx_t'(1);
                    end
                end
                S_READ: begin
                    if (r_rcnt == LAST_IDX) begin
                        r_rcnt <= '0;
                        if (r_frame_ready) begin
                            r_rbank <= r_ready_bank;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_idx   = r_out_idx;
    assign bus.dor       = r_dor;
    assign bus.doi       = r_doi;

endmodule

// File: tb/tb_ifft_bitrev_reorder.sv
// Self-checking bench for ifft_bitrev_reorder: scoreboard of natural-order samples plus vector table.
module tb_ifft_bitrev_reorder;
    import ifft_pkg::*;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        int                   idx;
        bit                   last;
    } exp_t;

    typedef struct {
        logic signed [DW-1:0] din;
        logic signed [DW-1:0] exp_s;
    } vec_t;

    logic clk;
    logic rst;
    ifft_bitrev_reorder_if bus();

    ifft_bitrev_reorder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t                 sb[$];
    int                   checks = 0;
    int                   errors = 0;
    int                   cyc = 0;
    int                   first_out_cyc = -1;
    int                   first_acc_cyc = -1;
    int                   last_acc_cyc = -1;
    int                   run_len = 0;
    int                   max_run = 0;
    int                   seam_cnt = 0;
    bit                   prev_last = 1'b0;
    logic signed [DW-1:0] cap_re [32];
    logic signed [DW-1:0] cap_im [32];
    logic signed [DW-1:0] frm_re [32];
    logic signed [DW-1:0] frm_im [32];
    vec_t                 vt [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int tb_rev(input int v);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (v[b]) r = r | (1 << (4 - b));
        end
        return r;
    endfunction

    function automatic logic signed [DW-1:0] tb_model(input logic signed [DW-1:0] x);
`ifdef IFFT_SCALE_EN
        longint t;
        t = (longint'(x) + 64'sd16) >>> 5;
        if (t > 64'sd268435455) t = 64'sd268435455;
        return t[DW-1:0];
`else
        return x;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.out_valid) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (prev_last && bus.out_idx == 0) seam_cnt++;
                cap_re[bus.out_idx] = bus.dor;
                cap_im[bus.out_idx] = bus.doi;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got idx=%0d dor=%0d doi=%0d, required no output",
                             bus.out_idx, bus.dor, bus.doi);
                end else begin
                    e = sb.pop_front();
                    if (bus.dor !== e.re || bus.doi !== e.im || bus.out_idx !== e.idx[4:0] || bus.out_last !== e.last) begin
                        errors++;
                        $display("FAIL sample: got idx=%0d last=%0b dor=%0d doi=%0d, required idx=%0d last=%0b dor=%0d doi=%0d",
                                 bus.out_idx, bus.out_last, bus.dor, bus.doi, e.idx, e.last, e.re, e.im);
                    end else begin
                        $display("sample idx=%0d last=%0b dor=%0d doi=%0d ok", bus.out_idx, bus.out_last, bus.dor, bus.doi);
                    end
                end
            end else begin
                run_len = 0;
            end
            prev_last = bus.out_valid && bus.out_last;
        end
    end

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        bus.dir      = 'x;
        bus.dii      = 'x;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit gapped, input int nsamp);
        int k;
        for (int n = 0; n < 32; n++) begin
            k = tb_rev(n);
            sb.push_back('{re: tb_model(frm_re[k]), im: tb_model(frm_im[k]), idx: n, last: (n == 31)});
        end
        for (int i = 0; i < nsamp; i++) begin
            bus.in_valid = 1'b1;
            bus.dir      = frm_re[i];
            bus.dii      = frm_im[i];
            @(posedge clk);
            #1;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            if (gapped) idle_cycle();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d samples pending, required 0", name, sb.size());
            sb.delete();
        end else begin
            $display("check %s_drain: queue empty ok", name);
        end
    endtask

    task automatic clear_stats();
        first_out_cyc = -1;
        first_acc_cyc = -1;
        last_acc_cyc  = -1;
        max_run       = 0;
        seam_cnt      = 0;
    endtask

    task automatic load_ordering();
        for (int k = 0; k < 32; k++) begin
            frm_re[k] = DW'(k);
            frm_im[k] = DW'(k << 16);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check_eq({name, "_valid"}, int'(bus.out_valid), 0);
        check_eq({name, "_last"},  int'(bus.out_last), 0);
        check_eq({name, "_idx"},   int'(bus.out_idx), 0);
        check_eq({name, "_dor"},   int'(bus.dor), 0);
        check_eq({name, "_doi"},   int'(bus.doi), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic signed [DW-1:0] exp_v;
        vt[0] = '{din: 29'sd32,        exp_s: 29'sd1};
        vt[1] = '{din: 29'sd47,        exp_s: 29'sd1};
        vt[2] = '{din: 29'sd48,        exp_s: 29'sd2};
        vt[3] = '{din: -29'sd48,       exp_s: -29'sd1};
        vt[4] = '{din: 29'sd268435455, exp_s: 29'sd8388608};
        vt[5] = '{din: 29'sd0,         exp_s: 29'sd0};
        vt[6] = '{din: 29'sd15,        exp_s: 29'sd0};
        vt[7] = '{din: -29'sd17,       exp_s: -29'sd1};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.dir      = '0;
        bus.dii      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset_init");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ordering: single frame, continuous input.
        load_ordering();
        clear_stats();
        send_frame(1'b0, 32);
        wait_drain("ordering");
        check_eq("ordering_latency", first_out_cyc - first_acc_cyc, 32);
        check_eq("ordering_burst", max_run, 32);

        // Four back-to-back frames: continuous output, zero-bubble seams.
        clear_stats();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 32; k++) begin
                frm_re[k] = DW'(f * 100 + k);
                frm_im[k] = DW'(-(f * 100 + k) * 3);
            end
            send_frame(1'b0, 32);
        end
        wait_drain("b2b");
        check_eq("b2b_latency", first_out_cyc - first_acc_cyc, 32);
        check_eq("b2b_burst", max_run, 128);
        check_eq("b2b_seams", seam_cnt, 3);

        // Gapped input: output burst begins one edge after the last accepted sample.
        load_ordering();
        clear_stats();
        send_frame(1'b1, 32);
        wait_drain("gapped");
        check_eq("gapped_start", first_out_cyc - last_acc_cyc, 1);
        check_eq("gapped_burst", max_run, 32);

        // Scaling vector table on natural indices 0..7.
        for (int k = 0; k < 32; k++) begin
            n = tb_rev(k);
            if (n < 8) begin
                frm_re[k] = vt[n].din;
                frm_im[k] = vt[(n + 1) % 8].din;
            end else begin
                frm_re[k] = DW'(n * 1000);
                frm_im[k] = DW'(-n);
            end
        end
        clear_stats();
        send_frame(1'b0, 32);
        wait_drain("table");
        for (int i = 0; i < 8; i++) begin
`ifdef IFFT_SCALE_EN
            exp_v = vt[i].exp_s;
            check_eq($sformatf("table_re%0d", i), int'(cap_re[i]), int'(exp_v));
            exp_v = vt[(i + 1) % 8].exp_s;
            check_eq($sformatf("table_im%0d", i), int'(cap_im[i]), int'(exp_v));
`else
            exp_v = vt[i].din;
            check_eq($sformatf("table_re%0d", i), int'(cap_re[i]), int'(exp_v));
            exp_v = vt[(i + 1) % 8].din;
            check_eq($sformatf("table_im%0d", i), int'(cap_im[i]), int'(exp_v));
`endif
        end

        // Reset mid-frame while a readout is in progress.
        load_ordering();
        send_frame(1'b0, 32);
        for (int k = 0; k < 32; k++) begin
            frm_re[k] = DW'(5000 + k);
            frm_im[k] = DW'(7 * k);
        end
        send_frame(1'b0, 13);
        #3;
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_mid");
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        load_ordering();
        clear_stats();
        send_frame(1'b0, 32);
        wait_drain("post_reset");
        check_eq("post_reset_latency", first_out_cyc - first_acc_cyc, 32);
        check_eq("post_reset_burst", max_run, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
